// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if
// Configuration handshake between the SPI register bank (master) and the
// PWM ramp sequencer (slave).
//   cfg_valid    master -> slave  config strobe
//   cfg_ready    slave  -> master sequencer can accept a config
//   cfg_target   master -> slave  target duty
//   cfg_step     master -> slave  duty increment per step (0 = jump to target)
//   cfg_interval master -> slave  step every cfg_interval+1 PWM periods
//   cfg_en_out   master -> slave  output-enable mask to apply
//   cfg_en_pwm   master -> slave  PWM-enable mask to apply
interface pwm_ramp_sequencer_if #(
  parameter int CH     = 16,
  parameter int DUTY_W = 8,
  parameter int IVL_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DUTY_W-1:0] cfg_target;
  logic [DUTY_W-1:0] cfg_step;
  logic [IVL_W-1:0]  cfg_interval;
  logic [CH-1:0]     cfg_en_out;
  logic [CH-1:0]     cfg_en_pwm;

  modport master (
    output cfg_valid, cfg_target, cfg_step, cfg_interval, cfg_en_out, cfg_en_pwm,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_target, cfg_step, cfg_interval, cfg_en_out, cfg_en_pwm,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Sits between the SPI register bank and the PWM peripheral. A configuration
// is latched into shadow registers, its enable masks are applied on the next
// PWM period boundary, and the duty cycle is then ramped toward the target one
// step every (interval+1) PWM periods. All duty/enable changes happen on
// pwm_period_end edges so the PWM never sees a mid-period update.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   cfg             configuration handshake (slave side)
//   abort           cancel a pending or running ramp, outputs hold
//   pwm_period_end  one-cycle pulse at PWM counter wrap
//   duty_out        duty cycle to the PWM peripheral
//   en_out, en_pwm  applied output / PWM enable masks
//   busy            high while a config is pending or ramping
//   done            one-cycle pulse when duty_out reaches the target
module pwm_ramp_sequencer #(
  parameter int CH     = 16,
  parameter int DUTY_W = 8,
  parameter int IVL_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  pwm_ramp_sequencer_if.slave cfg,
  input  logic                abort,
  input  logic                pwm_period_end,
  output logic [DUTY_W-1:0]   duty_out,
  output logic [CH-1:0]       en_out,
  output logic [CH-1:0]       en_pwm,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SYNC, RAMP, DONE} state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] stp_q, stp_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [CH-1:0]     sh_en_out_q, sh_en_out_d;
  logic [CH-1:0]     sh_en_pwm_q, sh_en_pwm_d;
  logic [IVL_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CH-1:0]     en_out_q, en_out_d;
  logic [CH-1:0]     en_pwm_q, en_pwm_d;

  // One ramp step from cur toward tgt, clamped at tgt. Worked in two extra
  // signed bits so neither cur+stp overflows past 2^DUTY_W-1 nor cur-stp
  // wraps below zero before the clamp is applied.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] stp
  );
    logic signed [DUTY_W+1:0] cur_s, tgt_s, up_s, dn_s;
    logic [DUTY_W-1:0]        res;
    cur_s = $signed({2'b00, cur});
    tgt_s = $signed({2'b00, tgt});
    up_s  = cur_s + $signed({2'b00, stp});
    dn_s  = cur_s - $signed({2'b00, stp});
    if (stp == '0)
      res = tgt;
    else if (cur < tgt)
      res = (up_s >= tgt_s) ? tgt : up_s[DUTY_W-1:0];
    else
      res = (dn_s <= tgt_s) ? tgt : dn_s[DUTY_W-1:0];
    return res;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      stp_q       <= '0;
      ivl_q       <= '0;
      sh_en_out_q <= '0;
      sh_en_pwm_q <= '0;
      cnt_q       <= '0;
      duty_q      <= '0;
      en_out_q    <= '0;
      en_pwm_q    <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stp_q       <= stp_d;
      ivl_q       <= ivl_d;
      sh_en_out_q <= sh_en_out_d;
      sh_en_pwm_q <= sh_en_pwm_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      en_out_q    <= en_out_d;
      en_pwm_q    <= en_pwm_d;
    end
  end

  // Next state and register updates
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    stp_d       = stp_q;
    ivl_d       = ivl_q;
    sh_en_out_d = sh_en_out_q;
    sh_en_pwm_d = sh_en_pwm_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    en_out_d    = en_out_q;
    en_pwm_d    = en_pwm_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_valid) begin
          tgt_d       = cfg.cfg_target;
          stp_d       = cfg.cfg_step;
          ivl_d       = cfg.cfg_interval;
          sh_en_out_d = cfg.cfg_en_out;
          sh_en_pwm_d = cfg.cfg_en_pwm;
          state_d     = SYNC;
        end
      end
      SYNC: begin
        // abort outranks a coincident period boundary: nothing is applied
        if (abort) begin
          state_d = IDLE;
        end else if (pwm_period_end) begin
          en_out_d = sh_en_out_q;
          en_pwm_d = sh_en_pwm_q;
          cnt_d    = ivl_q;
          state_d  = (duty_q == tgt_q) ? DONE : RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pwm_period_end) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - IVL_W'(1);
          end else begin
            duty_d = step_toward(duty_q, tgt_q, stp_q);
            cnt_d  = ivl_q;
            if (duty_d == tgt_q)
              state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    cfg.cfg_ready = (state_q == IDLE);
    busy          = (state_q == SYNC) || (state_q == RAMP);
    done          = (state_q == DONE);
    duty_out      = duty_q;
    en_out        = en_out_q;
    en_pwm        = en_pwm_q;
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;
  localparam int CH  = 16;
  localparam int DW  = 8;
  localparam int IW  = 8;
  localparam int GAP = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          pe;
  logic [DW-1:0] duty_out;
  logic [CH-1:0] en_out;
  logic [CH-1:0] en_pwm;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // reference state of the outputs as the bench expects them
  int m_duty = 0;
  int m_eo   = 0;
  int m_ep   = 0;

  pwm_ramp_sequencer_if #(.CH(CH), .DUTY_W(DW), .IVL_W(IW)) cfg_if ();

  pwm_ramp_sequencer #(.CH(CH), .DUTY_W(DW), .IVL_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg_if),
    .abort          (abort),
    .pwm_period_end (pe),
    .duty_out       (duty_out),
    .en_out         (en_out),
    .en_pwm         (en_pwm),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    pe = 1'b1;
    tick();
    pe = 1'b0;
  endtask

  task automatic drive_fields(input int t, input int s, input int iv, input int eo, input int ep);
    cfg_if.cfg_target   = DW'(t);
    cfg_if.cfg_step     = DW'(s);
    cfg_if.cfg_interval = IW'(iv);
    cfg_if.cfg_en_out   = CH'(eo);
    cfg_if.cfg_en_pwm   = CH'(ep);
  endtask

  task automatic do_cfg(input int t, input int s, input int iv, input int eo, input int ep);
    int w;
    w = 0;
    while (!cfg_if.cfg_ready && w < 50) begin
      tick();
      w++;
    end
    chk("cfg_ready_before_accept", cfg_if.cfg_ready, 1);
    drive_fields(t, s, iv, eo, ep);
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", cfg_if.cfg_ready, 0);
  endtask

  // next duty value from the plain ramp rule: move by step, never past target
  function automatic int model_next(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    return (cur - stp < tgt) ? tgt : cur - stp;
  endfunction

  task automatic run_ramp(input int t, input int s, input int iv, input int eo, input int ep,
                          input bit inject);
    int  q[$];
    int  cur;
    bit  last;
    do_cfg(t, s, iv, eo, ep);
    idle(3);
    chk("en_out_before_sync", en_out, m_eo);
    chk("en_pwm_before_sync", en_pwm, m_ep);
    pulse();
    m_eo = eo;
    m_ep = ep;
    chk("en_out_at_sync", en_out, m_eo);
    chk("en_pwm_at_sync", en_pwm, m_ep);
    chk("duty_at_sync", duty_out, m_duty);
    cur = m_duty;
    while (cur != t) begin
      cur = model_next(cur, t, s);
      q.push_back(cur);
    end
    if (q.size() == 0) begin
      chk("done_no_ramp", done, 1);
      tick();
      chk("done_no_ramp_clear", done, 0);
      chk("ready_no_ramp", cfg_if.cfg_ready, 1);
      return;
    end
    chk("done_at_sync", done, 0);
    idle(GAP);
    for (int k = 0; k < q.size(); k++) begin
      for (int j = 1; j <= iv + 1; j++) begin
        pulse();
        if (j == iv + 1) m_duty = q[k];
        last = (k == q.size() - 1) && (j == iv + 1);
        chk("duty_step", duty_out, m_duty);
        chk("done_step", done, last);
        chk("busy_step", busy, !last);
        if (inject && k == 0 && j == 1) begin
          chk("ready_mid_ramp", cfg_if.cfg_ready, 0);
          drive_fields(0, 1, 0, 0, 0);
          cfg_if.cfg_valid = 1'b1;
          tick();
          cfg_if.cfg_valid = 1'b0;
        end
        idle(GAP);
      end
    end
    chk("done_cleared", done, 0);
    chk("busy_after_ramp", busy, 0);
    chk("ready_after_ramp", cfg_if.cfg_ready, 1);
    chk("duty_final", duty_out, t);
  endtask

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    pe = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    drive_fields(0, 0, 0, 0, 0);
    idle(3);
    chk("rst_duty", duty_out, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_en_pwm", en_pwm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    rst = 1'b0;
    idle(2);

    // ramp up 0 -> 40 by 10, enables on the first boundary only
    run_ramp(40, 10, 0, 16'h00FF, 16'h000F, 1'b0);
    // jump to 250, then ramp down by 100 every second period: 150, 50, 3
    run_ramp(250, 0, 0, 16'h00FF, 16'h000F, 1'b0);
    run_ramp(3, 100, 1, 16'h0F00, 16'h00F0, 1'b0);
    // 200 -> 255 in one step, no wrap to 44; step 0 jumps straight to 7
    run_ramp(200, 0, 0, 16'h0001, 16'h0002, 1'b0);
    run_ramp(255, 100, 0, 16'h0003, 16'h0004, 1'b0);
    run_ramp(7, 0, 0, 16'h0005, 16'h0006, 1'b0);
    // cfg_valid mid-ramp is ignored, original target reached
    run_ramp(100, 10, 0, 16'hC0DE, 16'hBEEF, 1'b1);

    // abort coincident with a period boundary at duty 30
    do_cfg(0, 35, 0, 16'h1111, 16'h2222);
    pulse();
    m_eo = 16'h1111;
    m_ep = 16'h2222;
    idle(GAP);
    pulse();
    chk("abort_pre_65", duty_out, 65);
    idle(GAP);
    pulse();
    m_duty = 30;
    chk("abort_pre_30", duty_out, 30);
    idle(GAP);
    pe = 1'b1;
    abort = 1'b1;
    tick();
    pe = 1'b0;
    abort = 1'b0;
    chk("abort_duty_hold", duty_out, 30);
    chk("abort_no_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_if.cfg_ready, 1);
    chk("abort_en_hold", en_out, m_eo);
    idle(5);
    chk("abort_no_done_later", done, 0);
    chk("abort_duty_later", duty_out, 30);

    // abort in SYNC with a coincident boundary: new masks never applied
    do_cfg(100, 10, 0, 16'h1234, 16'h5678);
    idle(2);
    pe = 1'b1;
    abort = 1'b1;
    tick();
    pe = 1'b0;
    abort = 1'b0;
    chk("sync_abort_en_out", en_out, m_eo);
    chk("sync_abort_en_pwm", en_pwm, m_ep);
    chk("sync_abort_ready", cfg_if.cfg_ready, 1);
    chk("sync_abort_duty", duty_out, 30);

    // reset mid-ramp
    do_cfg(200, 10, 0, 16'hAAAA, 16'h5555);
    pulse();
    chk("rstmid_en_out", en_out, 16'hAAAA);
    idle(GAP);
    pulse();
    chk("rstmid_duty_40", duty_out, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_duty = 0;
    m_eo = 0;
    m_ep = 0;
    chk("rstmid_duty", duty_out, 0);
    chk("rstmid_en_out0", en_out, 0);
    chk("rstmid_en_pwm0", en_pwm, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_ready", cfg_if.cfg_ready, 1);
    tick();
    chk("rstmid_done_later", done, 0);

    // cfg_valid coincident with a boundary: that boundary does not sync
    drive_fields(0, 5, 0, 16'h0F0F, 16'hF0F0);
    cfg_if.cfg_valid = 1'b1;
    pe = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    pe = 1'b0;
    chk("coinc_en_out", en_out, 0);
    chk("coinc_busy", busy, 1);
    idle(5);
    chk("coinc_en_out_wait", en_out, 0);
    pulse();
    m_eo = 16'h0F0F;
    m_ep = 16'hF0F0;
    chk("coinc_en_out_applied", en_out, m_eo);
    chk("coinc_en_pwm_applied", en_pwm, m_ep);
    chk("coinc_done", done, 1);
    tick();
    chk("coinc_done_clear", done, 0);
    chk("coinc_ready", cfg_if.cfg_ready, 1);

    // randomized ramps against the reference rule
    for (int r = 0; r < 8; r++) begin
      int t, s, iv, eo, ep;
      t  = $urandom_range(0, 255);
      s  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(15, 120);
      iv = $urandom_range(0, 2);
      eo = $urandom_range(0, 16'hFFFF);
      ep = $urandom_range(0, 16'hFFFF);
      run_ramp(t, s, iv, eo, ep, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Controller between the SPI register bank and the PWM peripheral.
- Accepts a configuration transaction: target duty, step size, step interval and 16-bit output/PWM enable masks.
- Applies new enables only on a PWM period boundary, then ramps the duty cycle toward the target one step per N PWM periods. Duty changes are therefore glitch-free and never land mid-period.

Parameters:
- CH, 16, number of output channels (width of the enable masks)
- DUTY_W, 8, duty-cycle width
- IVL_W, 8, step-interval counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  config strobe from SPI register bank
- cfg_ready  out  1  sequencer can accept config
- cfg_target  in  DUTY_W  target duty
- cfg_step  in  DUTY_W  duty increment per step; 0 = jump directly to target
- cfg_interval  in  IVL_W  step every cfg_interval+1 PWM periods
- cfg_en_out  in  CH  output-enable mask to apply
- cfg_en_pwm  in  CH  PWM-enable mask to apply
- abort  in  1  cancel the ramp in progress
- pwm_period_end  in  1  one-cycle pulse at PWM counter wrap
- duty_out  out  DUTY_W  duty cycle driven to the PWM peripheral
- en_out  out  CH  applied output-enable mask
- en_pwm  out  CH  applied PWM-enable mask
- busy  out  1  high from config accept until done or abort
- done  out  1  one-cycle pulse when duty_out reaches target

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high and has priority over every other input.
- Reset values: duty_out=0, en_out=0, en_pwm=0, busy=0, done=0, cfg_ready=1, state=IDLE, all shadow registers and counters 0.
- States: IDLE, SYNC, RAMP, DONE.
- IDLE:
  - cfg_ready=1, busy=0.
  - On cfg_valid: latch target, step, interval and both masks into shadow registers; go to SYNC.
  - busy=1 and cfg_ready=0 from the next cycle.
- SYNC:
  - Wait for pwm_period_end. A pulse coincident with the accept cycle does not count.
  - On the first pulse: en_out/en_pwm <= shadow masks on that edge, interval counter <= interval.
  - If duty_out == target, go to DONE. Otherwise go to RAMP.
- RAMP, on each pwm_period_end:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, take one step and reload the counter with interval.
  - Step up (duty_out < target): duty_out <= min(duty_out+step, target), computed in DUTY_W+1 bits, so there is no wrap at 255.
  - Step down (duty_out > target): duty_out <= max(duty_out-step, target), with no underflow below 0.
  - step == 0: duty_out <= target on the first step.
  - When the new duty_out equals target, go to DONE.
  - duty_out changes only on pwm_period_end edges.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE. cfg_ready=0 in DONE.
- Latency: duty_out first changes at the (interval+1)-th period_end after the sync pulse. A full ramp takes ceil(|target-start|/step) steps.
- cfg_valid while cfg_ready=0 is ignored. The SPI side must retry, and shadow registers are not overwritten.
- abort:
  - In SYNC or RAMP: go to IDLE next cycle. duty_out and the enables hold their current values, and done does not pulse.
  - If abort and pwm_period_end arrive in the same cycle, abort wins: no step and no enable apply.
  - abort in IDLE or DONE has no effect.
- rst mid-ramp: everything returns to reset values on that edge. No done pulse.
- Outputs are registered. No combinational path from inputs to duty_out, en_*, busy or done; cfg_ready is decoded from state only.

Test Plan:
1. Reset, cfg_valid with target=40, step=10, interval=0, en_out=0x00FF, en_pwm=0x000F, then period_end pulses every 20 clk -> enables change only on the 1st pulse; duty_out 10, 20, 30, 40 on pulses 2-5; done pulses once after 40; busy low afterwards.
2. From duty_out=250: target=3, step=100, interval=1 -> duty_out 150, 50, 3 on every second period_end; no underflow; done once.
3. From duty_out=200: target=255, step=100 -> single step to 255 (not 44); step=0, target=7 -> duty_out=7 on the first step.
4. Config accepted; second cfg_valid with target=0 mid-ramp -> ignored, cfg_ready=0, ramp continues to the original target.
5. abort during RAMP at duty_out=30, coincident with period_end -> duty_out stays 30, no done, IDLE with cfg_ready=1 next cycle. Separately, rst asserted mid-ramp -> all outputs 0 on the next edge.
6. cfg_valid coincident with period_end in IDLE -> enables are not applied until the following period_end.
